// File: rtl/branch_resolve_predict.sv
// Branch predictor and resolver. A direct-mapped BTB with 2-bit counters predicts
// the fetch PC, and resolved EX/MEM branches raise flush, train the table and update statistics.
module branch_resolve_predict #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        prediction,
    output logic [31:0] control_pc,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred,
    input  logic [31:0] ex_pred_target,
    output logic        flush,
    output logic [31:0] pc_branch,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);
    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [31:0]      r_br_count;
    logic [31:0]      r_mispred_count;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;

    // Lookup reads the table before any same-cycle training write lands.
    assign w_idx      = if_pc[IDX_W+1:2];
    assign w_tag      = if_pc[31:IDX_W+2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign prediction = w_hit && r_ctr[w_idx][1];
    assign control_pc = prediction ? r_target[w_idx] : if_pc + 32'd4;

    assign flush     = ex_valid && ((ex_taken != ex_pred) ||
                                    (ex_taken && ex_pred && (ex_target != ex_pred_target)));
    assign pc_branch = ex_taken ? ex_target : ex_pc + 32'd4;

    assign w_uidx = ex_pc[IDX_W+1:2];
    assign w_utag = ex_pc[31:IDX_W+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (ex_valid) begin
                if (w_uhit) begin
                    if (ex_taken) begin
                        if (r_ctr[w_uidx] != 2'b11) r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
                        r_target[w_uidx] <= ex_target;
                    end else if (r_ctr[w_uidx] != 2'b00) begin
                        r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
                    end
                end else if (ex_taken) begin
                    r_valid[w_uidx]  <= 1'b1;
                    r_tag[w_uidx]    <= w_utag;
                    r_target[w_uidx] <= ex_target;
                    r_ctr[w_uidx]    <= 2'b10;
                end
                if (r_br_count != '1) r_br_count <= r_br_count + 32'd1;
            end
            if (flush && (r_mispred_count != '1)) r_mispred_count <= r_mispred_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Bench for branch_resolve_predict: a directed vector table, a reset/saturation sequence,
// and random traffic checked against an array-based BTB model.
module tb_branch_resolve_predict;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        prediction;
    logic [31:0] control_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred;
    logic [31:0] ex_pred_target;
    logic        flush;
    logic [31:0] pc_branch;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int total = 0;
    int bad   = 0;

    branch_resolve_predict #(.IDX_W(4), .TAG_W(26)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .prediction(prediction), .control_pc(control_pc),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred(ex_pred), .ex_pred_target(ex_pred_target), .flush(flush),
        .pc_branch(pc_branch), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: 16 entries addressed by word index modulo 16, tag = pc / 64.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_br, m_mis;

    typedef struct {
        logic [31:0] ipc;
        logic        v;
        logic [31:0] epc;
        logic        tk;
        logic [31:0] tgt;
        logic        pr;
        logic [31:0] ptgt;
        logic        e_pred;
        logic [31:0] e_cpc;
        logic        e_flush;
        logic [31:0] e_pcb;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_br = 0; m_mis = 0;
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / 64);
    endfunction

    function automatic bit m_predict(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_cpc(input logic [31:0] pc);
        return m_predict(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_flush();
        if (!ex_valid) return 0;
        if (ex_taken != ex_pred) return 1;
        return ex_taken && (ex_target != ex_pred_target);
    endfunction

    task automatic m_train();
        int i;
        bit f;
        f = m_flush();
        i = m_idx(ex_pc);
        if (ex_valid) begin
            if (m_hit(ex_pc)) begin
                if (ex_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (ex_taken) begin
                m_valid[i] = 1; m_tag[i] = ex_pc / 64; m_tgt[i] = ex_target; m_ctr[i] = 2;
            end
            if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        end
        if (f && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".prediction"}, {31'd0, prediction}, {31'd0, m_predict(if_pc)});
        chk({tag, ".control_pc"}, control_pc, m_cpc(if_pc));
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush()});
        chk({tag, ".pc_branch"}, pc_branch, ex_taken ? ex_target : ex_pc + 32'd4);
        chk({tag, ".br_count"}, br_count, m_br);
        chk({tag, ".mispred_count"}, mispred_count, m_mis);
    endtask

    task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] epc,
                         input logic tk, input logic [31:0] tgt, input logic pr,
                         input logic [31:0] ptgt);
        if_pc = ipc; ex_valid = v; ex_pc = epc; ex_taken = tk;
        ex_target = tgt; ex_pred = pr; ex_pred_target = ptgt;
    endtask

    task automatic step();
        @(posedge clk);
        m_train();
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom_range(0, 6))
            0: return 32'h100;
            1: return 32'h140;
            2: return 32'h180;
            3: return 32'h104;
            4: return 32'h204;
            5: return 32'hFFFF_FFFC;
            default: return {$urandom()} & 32'hFFFF_FFFC;
        endcase
    endfunction

    function automatic logic [31:0] pick_tgt();
        case ($urandom_range(0, 3))
            0: return 32'h200;
            1: return 32'h280;
            2: return 32'h300;
            default: return {$urandom()} & 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        logic [31:0] epc;
        logic        tk;

        tbl[0]  = '{32'h100, 0, 32'h100, 0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 32'h104};
        tbl[1]  = '{32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104, 1, 32'h200};
        tbl[2]  = '{32'h100, 1, 32'h100, 0, 32'h200, 1, 32'h200, 1, 32'h200, 1, 32'h104};
        tbl[3]  = '{32'h100, 1, 32'h100, 0, 32'h200, 0, 32'h104, 0, 32'h104, 0, 32'h104};
        tbl[4]  = '{32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104, 1, 32'h200};
        tbl[5]  = '{32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104, 1, 32'h200};
        tbl[6]  = '{32'h100, 0, 32'h100, 0, 32'h000, 0, 32'h000, 1, 32'h200, 0, 32'h104};
        tbl[7]  = '{32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h144, 0, 32'h144, 1, 32'h300};
        tbl[8]  = '{32'h100, 0, 32'h140, 0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 32'h144};
        tbl[9]  = '{32'h140, 1, 32'h140, 1, 32'h280, 1, 32'h300, 1, 32'h300, 1, 32'h280};
        tbl[10] = '{32'h140, 0, 32'h140, 0, 32'h000, 0, 32'h000, 1, 32'h280, 0, 32'h144};
        tbl[11] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000};
        tbl[12] = '{32'h204, 1, 32'h204, 1, 32'h400, 0, 32'h208, 0, 32'h208, 1, 32'h400};
        tbl[13] = '{32'h204, 0, 32'h204, 0, 32'h000, 0, 32'h000, 1, 32'h400, 0, 32'h208};

        rst = 1'b1;
        drive(32'h100, 0, 32'h100, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("reset.br_count", br_count, 32'd0);
        chk("reset.mispred_count", mispred_count, 32'd0);
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ipc, tbl[i].v, tbl[i].epc, tbl[i].tk, tbl[i].tgt, tbl[i].pr, tbl[i].ptgt);
            #1;
            chk($sformatf("vec%0d.prediction", i), {31'd0, prediction}, {31'd0, tbl[i].e_pred});
            chk($sformatf("vec%0d.control_pc", i), control_pc, tbl[i].e_cpc);
            chk($sformatf("vec%0d.flush", i), {31'd0, flush}, {31'd0, tbl[i].e_flush});
            chk($sformatf("vec%0d.pc_branch", i), pc_branch, tbl[i].e_pcb);
            step();
        end
        chk("table.br_count", br_count, 32'd9);
        chk("table.mispred_count", mispred_count, 32'd7);

        // Asynchronous reset arriving while a taken branch is being resolved.
        drive(32'h140, 1, 32'h140, 1, 32'h500, 0, 32'h144);
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("rst.prediction", {31'd0, prediction}, 32'd0);
        chk("rst.control_pc", control_pc, 32'h144);
        chk("rst.br_count", br_count, 32'd0);
        chk("rst.mispred_count", mispred_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h140, 0, 32'h140, 0, 0, 0, 0);
        #1;
        chk("post_rst.prediction", {31'd0, prediction}, 32'd0);
        step();

        for (int n = 0; n < 600; n++) begin
            epc = pick_pc();
            tk  = 1'($urandom_range(0, 1));
            drive(pick_pc(), 1'($urandom_range(0, 3) != 0), epc, tk, pick_tgt(), 1'b0, 32'h0);
            if ($urandom_range(0, 2) != 0) begin
                ex_pred = m_predict(epc);
                ex_pred_target = m_cpc(epc);
            end else begin
                ex_pred = 1'($urandom_range(0, 1));
                ex_pred_target = pick_tgt();
            end
            #1;
            check_model($sformatf("rand%0d", n));
            step();
        end

        // Preload the statistics near their ceiling, then keep mispredicting.
        dut.r_mispred_count = 32'hFFFF_FFFD;
        dut.r_br_count      = 32'hFFFF_FFFE;
        m_mis = 32'hFFFF_FFFD;
        m_br  = 32'hFFFF_FFFE;
        for (int n = 0; n < 4; n++) begin
            drive(32'h300, 1, 32'h300, 1, 32'h600, 0, 32'h304);
            #1;
            check_model($sformatf("sat%0d", n));
            step();
        end
        drive(32'h300, 0, 32'h300, 0, 0, 0, 0);
        #1;
        chk("sat.mispred_count", mispred_count, 32'hFFFF_FFFF);
        chk("sat.br_count", br_count, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
